// File: rtl/frame_scan_ctrl.sv
// -----------------------------------------------------------------------------
// frame_scan_ctrl
//
// Frame sequencer for the pixel read / threshold datapath. After an accepted
// start request it walks through a startup delay, a one-cycle vertical sync,
// and then for every line a horizontal blanking interval followed by the
// active-line phase. During the active line it presents byte addresses of
// even/odd pixel pairs in a packed 24-bit RGB buffer and handshakes each pair
// with the downstream read/threshold stage.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous reset, active low
//   frame_Start      single-cycle start request, honoured only while idle
//   abort            synchronous abort, back to idle on the next cycle
//   pixel_Ready      downstream accepts the presented pixel pair
//   pixel_Valid      a pixel-pair address is presented (active line only)
//   pixel_Addr       byte offset of the even pixel's first byte
//   row_Count        current line index
//   col_Count        even-pixel column index
//   vertical_Pulse   one-cycle frame sync
//   horizontal_Pulse high during active-line cycles
//   busy             high whenever the sequencer is not idle
//   done_Flag        one-cycle end-of-frame pulse
//
// Every output is a flop loaded from the next-state logic, so each output
// describes the state the sequencer is in during that cycle and there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------

// Property checker for the sequencer outputs; instantiated by the top level.
module frame_scan_ctrl_chk #(
  parameter int ADDR_WIDTH = 21
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  abort,
  input logic                  pixel_Ready,
  input logic                  pixel_Valid,
  input logic [ADDR_WIDTH-1:0] pixel_Addr,
  input logic                  vertical_Pulse,
  input logic                  horizontal_Pulse,
  input logic                  busy,
  input logic                  done_Flag
);

  // Frame sync and end-of-frame are mutually exclusive.
  a_sync_done_excl: assert property (@(posedge clk) disable iff (!reset)
    !(vertical_Pulse && done_Flag));

  // Horizontal pulse and valid both mark the active line and must agree.
  a_hpulse_valid: assert property (@(posedge clk) disable iff (!reset)
    horizontal_Pulse == pixel_Valid);

  // A presented pixel pair implies the sequencer is busy.
  a_valid_busy: assert property (@(posedge clk) disable iff (!reset)
    pixel_Valid |-> busy);

  // A stalled beat keeps its address and stays valid.
  a_stall_hold: assert property (@(posedge clk) disable iff (!reset)
    (pixel_Valid && !pixel_Ready && !abort) |=> (pixel_Valid && $stable(pixel_Addr)));

endmodule

module frame_scan_ctrl #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int START_DELAY  = 100,
  parameter int HSYNC_DELAY  = 160,
  parameter int ADDR_WIDTH   = 21,
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
  localparam int COL_W = $clog2(IMAGE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_Start,
  input  logic                  abort,
  input  logic                  pixel_Ready,
  output logic                  pixel_Valid,
  output logic [ADDR_WIDTH-1:0] pixel_Addr,
  output logic [ROW_W-1:0]      row_Count,
  output logic [COL_W-1:0]      col_Count,
  output logic                  vertical_Pulse,
  output logic                  horizontal_Pulse,
  output logic                  busy,
  output logic                  done_Flag
);

  // One shared delay counter serves both the startup and the blanking phases.
  localparam int MAX_DLY = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
  localparam int CNT_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

  localparam logic [CNT_W-1:0]      CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      START_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0]      HSYNC_LAST = CNT_W'(HSYNC_DELAY - 1);
  localparam logic [ROW_W-1:0]      ROW_ZERO   = ROW_W'(0);
  localparam logic [ROW_W-1:0]      ROW_ONE    = ROW_W'(1);
  localparam logic [ROW_W-1:0]      ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0]      COL_ZERO   = COL_W'(0);
  localparam logic [COL_W-1:0]      COL_TWO    = COL_W'(2);
  localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(IMAGE_WIDTH - 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = ADDR_WIDTH'(0);
  // Two RGB pixels per beat: 2 * 3 bytes.
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(6);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STARTUP = 3'd1,
    ST_VSYNC   = 3'd2,
    ST_HSYNC   = 3'd3,
    ST_DATA    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Byte offset of the next pixel pair. Lines are packed back to back, so the
  // step from the last pair of a line to the first pair of the next one is the
  // same +6 as within a line and no row*width product is ever needed.
  function automatic logic [ADDR_WIDTH-1:0] next_pair_addr(input logic [ADDR_WIDTH-1:0] addr);
    next_pair_addr = addr + ADDR_STEP;
  endfunction

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        dly_r, dly_s;
  logic [ROW_W-1:0]        row_r, row_s;
  logic [COL_W-1:0]        col_r, col_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic                    valid_r, valid_s;
  logic                    hpulse_r, hpulse_s;
  logic                    vpulse_r, vpulse_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    beat_s;

  // Next-state, counter and next-output logic.
  always_comb begin
    state_s = state_r;
    dly_s   = dly_r;
    row_s   = row_r;
    col_s   = col_r;
    addr_s  = addr_r;
    beat_s  = valid_r && pixel_Ready;

    if (abort) begin
      // Abort beats everything except reset, including a start in idle.
      state_s = ST_IDLE;
      dly_s   = CNT_ZERO;
      row_s   = ROW_ZERO;
      col_s   = COL_ZERO;
      addr_s  = ADDR_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          dly_s  = CNT_ZERO;
          row_s  = ROW_ZERO;
          col_s  = COL_ZERO;
          addr_s = ADDR_ZERO;
          if (frame_Start) begin
            state_s = ST_STARTUP;
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_STARTUP: begin
          if (dly_r == START_LAST) begin
            state_s = ST_VSYNC;
            dly_s   = CNT_ZERO;
          end else begin
            dly_s   = dly_r + CNT_ONE;
          end
        end

        ST_VSYNC: begin
          state_s = ST_HSYNC;
          dly_s   = CNT_ZERO;
          row_s   = ROW_ZERO;
          col_s   = COL_ZERO;
          addr_s  = ADDR_ZERO;
        end

        ST_HSYNC: begin
          // Address already points at the first pair of this line.
          col_s = COL_ZERO;
          if (dly_r == HSYNC_LAST) begin
            state_s = ST_DATA;
            dly_s   = CNT_ZERO;
          end else begin
            dly_s   = dly_r + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (beat_s) begin
            if (col_r == COL_LAST) begin
              if (row_r == ROW_LAST) begin
                // Final pair: hold position so the address never wraps.
                state_s = ST_DONE;
              end else begin
                state_s = ST_HSYNC;
                dly_s   = CNT_ZERO;
                row_s   = row_r + ROW_ONE;
                col_s   = COL_ZERO;
                addr_s  = next_pair_addr(addr_r);
              end
            end else begin
              col_s  = col_r + COL_TWO;
              addr_s = next_pair_addr(addr_r);
            end
          end else begin
            // Stall: hold everything, valid stays asserted.
            state_s = ST_DATA;
          end
        end

        ST_DONE: begin
          state_s = ST_IDLE;
          dly_s   = CNT_ZERO;
          row_s   = ROW_ZERO;
          col_s   = COL_ZERO;
          addr_s  = ADDR_ZERO;
        end

        default: begin
          state_s = ST_IDLE;
          dly_s   = CNT_ZERO;
          row_s   = ROW_ZERO;
          col_s   = COL_ZERO;
          addr_s  = ADDR_ZERO;
        end
      endcase
    end

    // Outputs are decoded from the state being entered so that the registered
    // copies line up with the state register.
    valid_s  = (state_s == ST_DATA);
    hpulse_s = (state_s == ST_DATA);
    vpulse_s = (state_s == ST_VSYNC);
    busy_s   = (state_s != ST_IDLE);
    done_s   = (state_s == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      dly_r    <= CNT_ZERO;
      row_r    <= ROW_ZERO;
      col_r    <= COL_ZERO;
      addr_r   <= ADDR_ZERO;
      valid_r  <= 1'b0;
      hpulse_r <= 1'b0;
      vpulse_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      dly_r    <= dly_s;
      row_r    <= row_s;
      col_r    <= col_s;
      addr_r   <= addr_s;
      valid_r  <= valid_s;
      hpulse_r <= hpulse_s;
      vpulse_r <= vpulse_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign pixel_Valid      = valid_r;
  assign pixel_Addr       = addr_r;
  assign row_Count        = row_r;
  assign col_Count        = col_r;
  assign vertical_Pulse   = vpulse_r;
  assign horizontal_Pulse = hpulse_r;
  assign busy             = busy_r;
  assign done_Flag        = done_r;

  frame_scan_ctrl_chk #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_chk (
    .clk              (clk),
    .reset            (reset),
    .abort            (abort),
    .pixel_Ready      (pixel_Ready),
    .pixel_Valid      (valid_r),
    .pixel_Addr       (addr_r),
    .vertical_Pulse   (vpulse_r),
    .horizontal_Pulse (hpulse_r),
    .busy             (busy_r),
    .done_Flag        (done_r)
  );

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for frame_scan_ctrl. Unit A is an 8x4 frame, unit B the 2x1
// boundary frame. Expected behaviour comes from a frame-level model: a list of
// pixel pairs in raster order plus the cycle arithmetic of delays and stalls.
// -----------------------------------------------------------------------------
module tb_frame_scan_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int SD = 3;
  localparam int HD = 2;

  logic       clk;
  logic       reset;

  logic       a_start, a_abort, a_ready;
  logic       a_valid, a_vp, a_hp, a_busy, a_done;
  logic [6:0] a_addr;
  logic [1:0] a_row;
  logic [2:0] a_col;

  logic       b_start, b_abort, b_ready;
  logic       b_valid, b_vp, b_hp, b_busy, b_done;
  logic [6:0] b_addr;
  logic [0:0] b_row;
  logic [0:0] b_col;

  int n_assert = 0;
  int n_fail   = 0;

  frame_scan_ctrl #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .START_DELAY(SD), .HSYNC_DELAY(HD), .ADDR_WIDTH(7)
  ) dut_a (
    .clk(clk), .reset(reset), .frame_Start(a_start), .abort(a_abort), .pixel_Ready(a_ready),
    .pixel_Valid(a_valid), .pixel_Addr(a_addr), .row_Count(a_row), .col_Count(a_col),
    .vertical_Pulse(a_vp), .horizontal_Pulse(a_hp), .busy(a_busy), .done_Flag(a_done)
  );

  frame_scan_ctrl #(
    .IMAGE_WIDTH(2), .IMAGE_HEIGHT(1), .START_DELAY(SD), .HSYNC_DELAY(HD), .ADDR_WIDTH(7)
  ) dut_b (
    .clk(clk), .reset(reset), .frame_Start(b_start), .abort(b_abort), .pixel_Ready(b_ready),
    .pixel_Valid(b_valid), .pixel_Addr(b_addr), .row_Count(b_row), .col_Count(b_col),
    .vertical_Pulse(b_vp), .horizontal_Pulse(b_hp), .busy(b_busy), .done_Flag(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_busy"},  a_busy,  32'd0);
    chk({tag, "_valid"}, a_valid, 32'd0);
    chk({tag, "_addr"},  a_addr,  32'd0);
    chk({tag, "_row"},   a_row,   32'd0);
    chk({tag, "_col"},   a_col,   32'd0);
    chk({tag, "_vp"},    a_vp,    32'd0);
    chk({tag, "_hp"},    a_hp,    32'd0);
    chk({tag, "_done"},  a_done,  32'd0);
  endtask

  // Run one frame on unit A against the frame-level model.
  // mode: 0 ready always high, 1 random ready, 2 five-cycle stall at address 12.
  task automatic run_a(input int mode, input int abort_addr, input bit restart,
                       output int done_cyc_obs, output int done_pulses);
    int  q_addr[$];
    int  q_row[$];
    int  q_col[$];
    int  cyc, exp_done, next_start, beats_left, stall_left;
    bit  in_line, stall_used, restarted, finished;

    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c += 2) begin
        q_addr.push_back((r * W + c) * 3);
        q_row.push_back(r);
        q_col.push_back(c);
      end
    end
    exp_done     = 1 << 30;
    next_start   = SD + 1 + HD + 1;
    in_line      = 1'b0;
    beats_left   = 0;
    stall_left   = 0;
    stall_used   = 1'b0;
    restarted    = 1'b0;
    finished     = 1'b0;
    done_cyc_obs = -1;
    done_pulses  = 0;

    a_start = 1'b1;
    a_ready = 1'b1;
    a_abort = 1'b0;
    tick();
    a_start = 1'b0;
    cyc = 1;

    while (!finished) begin
      if (cyc > 500) begin
        n_assert++;
        n_fail++;
        $error("FAIL timeout: observed cycle %0d expected end by %0d", cyc, 500);
        finished = 1'b1;
      end else begin
        if (cyc == next_start) begin
          in_line    = 1'b1;
          beats_left = W / 2;
        end
        chk("valid",  a_valid, {31'd0, in_line});
        chk("hpulse", a_hp,    {31'd0, in_line});
        chk("vpulse", a_vp,    {31'd0, (cyc == SD + 1)});
        chk("busy",   a_busy,  {31'd0, (cyc <= exp_done)});
        chk("done",   a_done,  {31'd0, (cyc == exp_done)});
        if (q_addr.size() > 0) begin
          chk("addr", a_addr, q_addr[0]);
          chk("row",  a_row,  q_row[0]);
          chk("col",  a_col,  q_col[0]);
        end else if (cyc > exp_done) begin
          chk("idle_addr", a_addr, 32'd0);
          chk("idle_row",  a_row,  32'd0);
          chk("idle_col",  a_col,  32'd0);
        end
        if (a_done) begin
          done_pulses++;
          done_cyc_obs = cyc;
        end
        if (cyc >= exp_done + 3) begin
          finished = 1'b1;
        end else begin
          // Stimulus for this cycle.
          case (mode)
            1: a_ready = ($urandom_range(3, 0) != 0);
            2: begin
              if (!stall_used && in_line && q_addr[0] == 12) begin
                stall_used = 1'b1;
                stall_left = 5;
              end
              if (stall_left > 0) begin
                a_ready = 1'b0;
                stall_left--;
              end else begin
                a_ready = 1'b1;
              end
            end
            default: a_ready = 1'b1;
          endcase
          if (restart && !restarted && in_line && q_row[0] == 1) begin
            a_start   = 1'b1;
            restarted = 1'b1;
          end else begin
            a_start = 1'b0;
          end
          if (abort_addr >= 0 && in_line && q_addr[0] == abort_addr) begin
            a_abort = 1'b1;
            tick();
            a_abort = 1'b0;
            chk_a_idle("abort");
            for (int k = 0; k < 3; k++) begin
              tick();
              chk("abort_after_done", a_done, 32'd0);
              chk("abort_after_busy", a_busy, 32'd0);
            end
            finished = 1'b1;
          end else begin
            // Model: a beat retires this cycle when the line is active and ready is high.
            if (in_line && a_ready) begin
              void'(q_addr.pop_front());
              void'(q_row.pop_front());
              void'(q_col.pop_front());
              beats_left--;
              if (beats_left == 0) begin
                in_line = 1'b0;
                if (q_addr.size() == 0) exp_done = cyc + 1;
                else next_start = cyc + HD + 1;
              end
            end
            tick();
            a_start = 1'b0;
            cyc++;
          end
        end
      end
    end
    a_start = 1'b0;
    a_ready = 1'b1;
  endtask

  int dc, dp;

  initial begin
    reset   = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1;

    // Reset state.
    #1;
    chk_a_idle("reset");
    tick();
    reset = 1'b1;
    tick();
    chk_a_idle("post_reset");

    // Nominal frame.
    run_a(0, -1, 1'b0, dc, dp);
    chk("nominal_done_cycle", dc, 32'd29);
    chk("nominal_done_count", dp, 32'd1);

    // Backpressure: five stalled cycles at address 12.
    run_a(2, -1, 1'b0, dc, dp);
    chk("stall_done_cycle", dc, 32'd34);
    chk("stall_done_count", dp, 32'd1);

    // Start while busy during row 1 is ignored.
    run_a(0, -1, 1'b1, dc, dp);
    chk("restart_done_cycle", dc, 32'd29);
    chk("restart_done_count", dp, 32'd1);

    // Abort at address 48, then a fresh nominal frame.
    run_a(0, 48, 1'b0, dc, dp);
    chk("abort_done_count", dp, 32'd0);
    run_a(0, -1, 1'b0, dc, dp);
    chk("after_abort_done_cycle", dc, 32'd29);

    // Random backpressure frames.
    for (int i = 0; i < 3; i++) begin
      run_a(1, -1, 1'b0, dc, dp);
      chk("random_done_count", dp, 32'd1);
    end

    // Asynchronous reset asserted between edges during blanking.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_reset_busy", a_busy, 32'd1);
    #4;
    reset = 1'b0;
    #1;
    chk_a_idle("async_reset");
    tick();
    #3;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_async_busy", a_busy, 32'd0);
      chk("post_async_valid", a_valid, 32'd0);
    end
    run_a(0, -1, 1'b0, dc, dp);
    chk("post_async_done_cycle", dc, 32'd29);

    // Abort together with start in idle stays idle.
    a_start = 1'b1;
    a_abort = 1'b1;
    tick();
    a_start = 1'b0;
    a_abort = 1'b0;
    chk("abort_start_busy", a_busy, 32'd0);
    tick();
    chk("abort_start_busy2", a_busy, 32'd0);

    // Boundary: 2x1 frame on unit B.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      chk("b_valid", b_valid, {31'd0, (cyc == 7)});
      chk("b_vpulse", b_vp,   {31'd0, (cyc == 4)});
      chk("b_done",  b_done,  {31'd0, (cyc == 8)});
      chk("b_busy",  b_busy,  {31'd0, (cyc <= 8)});
      chk("b_addr",  b_addr,  32'd0);
      chk("b_col",   b_col,   32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_scan_ctrl.md
Name: frame_scan_ctrl

Overview:
- Frame sequencer for the pixel read and threshold datapath.
- On a start request it runs the startup delay, vertical sync, per-line horizontal blanking and active-line phases.
- Issues byte addresses for even/odd pixel pairs into the 24-bit RGB image buffer, with a valid/ready handshake toward the read/threshold stage.
- Reports row/column position, sync pulses and frame completion.

Parameters:
- IMAGE_WIDTH, 768, pixels per line; must be even and >= 2.
- IMAGE_HEIGHT, 512, lines per frame; >= 1.
- START_DELAY, 100, idle cycles between accepted start and vertical sync; >= 1.
- HSYNC_DELAY, 160, blanking cycles before every line; >= 1.
- ADDR_WIDTH, 21, byte-address width; must hold IMAGE_WIDTH*IMAGE_HEIGHT*3-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_Start  in  1  single-cycle start request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- pixel_Ready  in  1  downstream accepts the current pixel pair.
- pixel_Valid  out  1  a pixel-pair address is presented.
- pixel_Addr  out  ADDR_WIDTH  byte offset of the even pixel's first byte.
- row_Count  out  clog2(IMAGE_HEIGHT)  current line index.
- col_Count  out  clog2(IMAGE_WIDTH)  even-pixel column index.
- vertical_Pulse  out  1  one-cycle frame sync.
- horizontal_Pulse  out  1  high during active-line (DATA) cycles.
- busy  out  1  high in every state except IDLE.
- done_Flag  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; all outputs and counters 0. Assertion mid-frame clears everything immediately. No resume after deassert; a new frame_Start is required.
- All outputs are registered. Each one reflects the current state, with no combinational path from inputs.
- State machine:
  - IDLE: frame_Start=1 -> STARTUP, delay counter=0.
  - STARTUP: count START_DELAY cycles -> VSYNC.
  - VSYNC: exactly 1 cycle, vertical_Pulse=1, row=0 -> HSYNC.
  - HSYNC: HSYNC_DELAY cycles, col=0 -> DATA.
  - DATA: pixel_Valid=1, horizontal_Pulse=1.
    - A beat completes on pixel_Valid and pixel_Ready in the same cycle; then col += 2 and pixel_Addr += 6.
    - pixel_Ready=0 stalls the beat: addr, col and row are held and pixel_Valid stays 1.
    - Beat completing at col=IMAGE_WIDTH-2:
      - If row<IMAGE_HEIGHT-1: row += 1 -> HSYNC.
      - Otherwise -> DONE.
  - DONE: 1 cycle, done_Flag=1, busy=1 -> IDLE.
- Address rule: pixel_Addr = (row*IMAGE_WIDTH + col)*3, maintained incrementally with no multiplier. The odd pixel sits at pixel_Addr+3.
- pixel_Addr holds its value in HSYNC, so the line-to-line step is continuous.
- Last address = IMAGE_WIDTH*IMAGE_HEIGHT*3 - 6. The counter never wraps within a frame and returns to 0 in IDLE.
- frame_Start while busy: ignored, with no queuing.
- abort: highest priority after reset, in any state.
  - Next cycle state=IDLE and outputs are 0.
  - done_Flag is not pulsed.
  - Simultaneous abort and frame_Start in IDLE -> stays IDLE.
- horizontal_Pulse and pixel_Valid are never high outside DATA. vertical_Pulse and done_Flag are never high together.

Test Plan:
Bench parameters: IMAGE_WIDTH=8, IMAGE_HEIGHT=4, START_DELAY=3, HSYNC_DELAY=2, ADDR_WIDTH=7.
- Nominal frame, pixel_Ready=1, frame_Start pulsed at cycle 0 -> STARTUP cycles 1-3, vertical_Pulse at cycle 4, then 4 lines of (2 HSYNC + 4 DATA). Addresses are 0,6,12,18 | 24..42 | 48..66 | 72..90. done_Flag=1 at cycle 29, busy=0 at cycle 30.
- Backpressure: hold pixel_Ready=0 for 5 cycles when pixel_Addr=12 -> pixel_Addr stays 12 with pixel_Valid=1 and col_Count=4 throughout. After release the sequence continues at 18, and the frame ends 5 cycles later than nominal.
- Start while busy: pulse frame_Start again during row 1 -> no effect, and exactly one done_Flag pulse is produced.
- Abort at pixel_Addr=48 (row 2) -> next cycle IDLE with busy=0, pixel_Valid=0, pixel_Addr=0 and no done_Flag. A new frame_Start replays the nominal sequence from address 0.
- Async reset low mid-HSYNC, asserted between clock edges -> all outputs 0 before the next edge. After release, state stays IDLE until frame_Start.
- Boundary: IMAGE_WIDTH=2, IMAGE_HEIGHT=1 -> a single DATA beat at address 0, then done_Flag on the following cycle.
